// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU and its combinational core.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_ACC = 3'b111
    } alu_op_e;

    localparam int unsigned FLAG_Z    = 0;
    localparam int unsigned FLAG_N    = 1;
    localparam int unsigned FLAG_C    = 2;
    localparam int unsigned FLAG_V    = 3;
    localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b, acc) -> (result, {V,C,N,Z}).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  alu_op_e              op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [WIDTH-1:0]     acc_i,
    output logic [WIDTH-1:0]     result_o,
    output logic [NUM_FLAGS-1:0] flags_o
);

    localparam int unsigned     Msb      = WIDTH - 1;
    localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] add_lhs;
    logic [WIDTH-1:0] add_rhs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             shift_in_range;
    logic [WIDTH-1:0] shl_mask;
    logic [WIDTH-1:0] shr_mask;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    always_comb begin
        // ACC shares the adder: acc + A.
        add_lhs        = (op_i == ALU_ACC) ? acc_i : a_i;
        add_rhs        = (op_i == ALU_ACC) ? a_i : b_i;
        sum            = {1'b0, add_lhs} + {1'b0, add_rhs};
        diff           = {1'b0, a_i} - {1'b0, b_i};
        shift_in_range = (b_i != '0) && (b_i < WidthVal);
        // One-hot select of the last bit shifted out; only meaningful when in range.
        shl_mask       = One << (WidthVal - b_i);
        shr_mask       = One << (b_i - One);

        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;

        unique case (op_i)
            ALU_ADD, ALU_ACC: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (add_lhs[Msb] == add_rhs[Msb]) && (res[Msb] != add_lhs[Msb]);
            end
            ALU_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a_i[Msb] != b_i[Msb]) && (res[Msb] != a_i[Msb]);
            end
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
            ALU_XOR: res = a_i ^ b_i;
            ALU_SHL: begin
                if (b_i == '0) begin
                    res = a_i;
                end else if (shift_in_range) begin
                    res   = a_i << b_i;
                    carry = |(a_i & shl_mask);
                end
            end
            ALU_SHR: begin
                if (b_i == '0) begin
                    res = a_i;
                end else if (shift_in_range) begin
                    res   = a_i >> b_i;
                    carry = |(a_i & shr_mask);
                end
            end
            default: res = '0;
        endcase

        result_o         = res;
        flags_o          = '0;
        flags_o[FLAG_Z]  = (res == '0);
        flags_o[FLAG_N]  = res[Msb];
        flags_o[FLAG_C]  = carry;
        flags_o[FLAG_V]  = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 computes, registers the
// result/flags and owns the accumulator.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           ALU_CONT,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     ALU_OUT,
    output logic [NUM_FLAGS-1:0] FLAGS
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    alu_op_e              s1_op_q, s1_op_d;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [WIDTH-1:0]     acc_q, acc_d;

    logic                 advance;
    logic                 commit;
    logic [WIDTH-1:0]     core_res;
    logic [NUM_FLAGS-1:0] core_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .acc_i    (acc_q),
        .result_o (core_res),
        .flags_o  (core_flags)
    );

    assign advance  = !out_valid_q || out_ready;
    assign commit   = advance && s1_valid_q;
    // S1 can refill while S2 is stalled as long as S1 itself is empty.
    assign in_ready = !rst && (advance || !s1_valid_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = A;
                s1_b_d  = B;
                s1_op_d = alu_op_e'(ALU_CONT);
            end
        end

        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d   = core_res;
                flags_d = core_flags;
            end
        end

        acc_d = acc_q;
        if (commit && (s1_op_q == ALU_ACC)) begin
            acc_d = core_res;
        end
        // Clear wins over a coinciding ACC commit; that op already used the old value.
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= ALU_ADD;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALU_OUT   = res_q;
    assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe (WIDTH=4) with an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALU_CONT;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_OUT;
    logic [3:0]   FLAGS;

    int total;
    int bad;
    int macc;
    logic [7:0] exp_q[$];

    alu_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_CONT  (ALU_CONT),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_OUT   (ALU_OUT),
        .FLAGS     (FLAGS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {V,C,N,Z,result} computed with plain integer arithmetic.
    function automatic logic [7:0] model(input int op, input int a, input int b, input int acc);
        int r, c, v, s, sa, sb, sc;
        c  = 0;
        v  = 0;
        r  = 0;
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        sc = (acc >= H) ? acc - M : acc;
        case (op)
            0: begin
                s = a + b;
                r = s % M;
                c = (s >= M) ? 1 : 0;
                v = ((sa + sb) >= H || (sa + sb) < -H) ? 1 : 0;
            end
            1: begin
                r = (a - b + M) % M;
                c = (a < b) ? 1 : 0;
                v = ((sa - sb) >= H || (sa - sb) < -H) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                if (b == 0) r = a;
                else if (b >= W) r = 0;
                else begin
                    r = (a << b) % M;
                    c = (a >> (W - b)) & 1;
                end
            end
            6: begin
                if (b == 0) r = a;
                else if (b >= W) r = 0;
                else begin
                    r = a >> b;
                    c = (a >> (b - 1)) & 1;
                end
            end
            default: begin
                s = acc + a;
                r = s % M;
                c = (s >= M) ? 1 : 0;
                v = ((sc + sa) >= H || (sc + sa) < -H) ? 1 : 0;
            end
        endcase
        return {v[0], c[0], (r >= H), (r == 0), 4'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] res, input logic [3:0] flg);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(ALU_OUT), 32'(res));
        chk({tag, "_flags"}, 32'(FLAGS), 32'(flg));
    endtask

    // One clock: drive at negedge, check the scoreboard head, update model at posedge.
    task automatic tick(input logic v, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic clr, input logic rdy);
        logic acc_ok;
        logic dlv;
        logic [7:0] e;
        in_valid  = v;
        ALU_CONT  = op;
        A         = a;
        B         = b;
        acc_clr   = clr;
        out_ready = rdy;
        #1;
        if (exp_q.size() == 0) begin
            chk("no_spurious_out", 32'(out_valid), 32'd0);
        end else if (out_valid) begin
            chk("scoreboard", 32'({FLAGS, ALU_OUT}), 32'(exp_q[0]));
        end
        acc_ok = v && in_ready;
        dlv    = out_valid && rdy;
        @(posedge clk);
        if (dlv && exp_q.size() > 0) void'(exp_q.pop_front());
        if (clr) macc = 0;
        if (acc_ok) begin
            e = model(int'(op), int'(a), int'(b), macc);
            if (op == 3'b111) macc = int'(e[3:0]);
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, rdy);
    endtask

    initial begin
        logic clr;
        total     = 0;
        bad       = 0;
        macc      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        ALU_CONT  = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_out", 32'(ALU_OUT), 32'd0);
        chk("rst_flags", 32'(FLAGS), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD latency and overflow
        tick(1'b1, 3'b000, 4'b0101, 4'b0011, 1'b0, 1'b1);
        chk("add_not_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        expect_out("add", 4'b1000, 4'b1010);

        // SUB borrow then zero, back to back
        tick(1'b1, 3'b001, 4'b0011, 4'b0101, 1'b0, 1'b1);
        tick(1'b1, 3'b001, 4'b0101, 4'b0101, 1'b0, 1'b1);
        expect_out("sub_borrow", 4'b1110, 4'b0110);
        idle(1'b1);
        expect_out("sub_zero", 4'b0000, 4'b0001);

        // shifts
        tick(1'b1, 3'b101, 4'b1001, 4'b0001, 1'b0, 1'b1);
        idle(1'b1);
        expect_out("shl1", 4'b0010, 4'b0100);
        tick(1'b1, 3'b110, 4'b1001, 4'b0100, 1'b0, 1'b1);
        idle(1'b1);
        expect_out("shr_width", 4'b0000, 4'b0001);
        tick(1'b1, 3'b110, 4'b1001, 4'b0000, 1'b0, 1'b1);
        idle(1'b1);
        expect_out("shr0", 4'b1001, 4'b0010);
        idle(1'b1);

        // backpressure
        tick(1'b1, 3'b000, 4'd1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 3'b000, 4'd2, 4'd2, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        expect_out("bp_first", 4'd2, 4'b0000);
        tick(1'b1, 3'b000, 4'd3, 4'd3, 1'b0, 1'b0);
        expect_out("bp_hold", 4'd2, 4'b0000);
        tick(1'b1, 3'b000, 4'd3, 4'd3, 1'b0, 1'b1);
        expect_out("bp_second", 4'd4, 4'b0000);
        idle(1'b1);
        expect_out("bp_third", 4'd6, 4'b0000);
        idle(1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // accumulator
        tick(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b1);
        tick(1'b1, 3'b111, 4'b0111, 4'h0, 1'b0, 1'b1);
        tick(1'b1, 3'b111, 4'b1100, 4'h0, 1'b0, 1'b1);
        expect_out("acc_first", 4'b0111, 4'b0000);
        idle(1'b1);
        expect_out("acc_carry", 4'b0011, 4'b0100);
        tick(1'b1, 3'b111, 4'b0001, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b1);
        expect_out("acc_clr_same", 4'b0100, 4'b0000);
        tick(1'b1, 3'b111, 4'b0001, 4'h0, 1'b0, 1'b1);
        idle(1'b1);
        expect_out("acc_after_clr", 4'b0001, 4'b0000);
        idle(1'b1);

        // asynchronous reset with two ops in flight
        tick(1'b1, 3'b000, 4'd5, 4'd5, 1'b0, 1'b0);
        tick(1'b1, 3'b000, 4'd1, 4'd2, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out", 32'(ALU_OUT), 32'd0);
        chk("async_rst_flags", 32'(FLAGS), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        macc = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle(1'b1);
        tick(1'b1, 3'b111, 4'b0010, 4'h0, 1'b0, 1'b1);
        idle(1'b1);
        expect_out("acc_post_rst", 4'b0010, 4'b0000);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            clr = (exp_q.size() == 0) && ($urandom_range(0, 7) == 0);
            tick(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), clr,
                 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() != 0) idle(1'b1);
        end
        chk("drain_count", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
